// File: rtl/mmu_pkg.sv
// Shared constants for the packet-store MMU: PID geometry, beat control
// codes and the free-list manager state encoding.
package mmu_pkg;

   localparam int PID_W         = 9;
   localparam int NUM_PIDS      = 1 << PID_W;
   localparam int BEATS_PER_PID = 32;

   localparam logic [7:0] CTL_INVALID = 8'h00;
   localparam logic [7:0] CTL_START   = 8'h01;
   localparam logic [7:0] CTL_PAYLOAD = 8'h02;
   localparam logic [7:0] CTL_END     = 8'h03;
   localparam logic [7:0] CTL_SINGLE  = 8'h04;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

endpackage

// File: rtl/pid_ram.sv
// Free-list storage: one synchronous write port, one asynchronous read port.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module pid_ram #(
   parameter int AW = 9,
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pid_alloc.sv
// PID free-list manager: FIFO of free packet-buffer slots with occupancy
// and sticky error reporting. After reset it fills itself with 0..N-1.
// Ports: clk, reset (sync, active-high); alloc_req -> alloc_gnt/alloc_pid
// one cycle later; free_valid/free_pid returns a PID (free_ready in READY);
// init_done, free_count, list_empty; sticky err_underflow, err_overflow.
// Option PID_ALLOC_DFREE_CHECK_EN: in-use bitmap plus sticky
// err_double_free output that rejects frees of PIDs not currently granted.
module pid_alloc
   import mmu_pkg::*;
#(
   parameter int PID_W = 9,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc_req,
   output logic             alloc_gnt,
   output logic [PID_W-1:0] alloc_pid,
   input  logic             free_valid,
   input  logic [PID_W-1:0] free_pid,
   output logic             free_ready,
   output logic             init_done,
   output logic [CNT_W-1:0] free_count,
   output logic             list_empty,
`ifdef PID_ALLOC_DFREE_CHECK_EN
   output logic             err_double_free,
`endif
   output logic             err_underflow,
   output logic             err_overflow
);

   localparam int               NUM_PIDS = 2 ** PID_W;
   localparam logic [CNT_W-1:0] C_FULL   = CNT_W'(NUM_PIDS);
   localparam logic [PID_W-1:0] C_LAST   = PID_W'(NUM_PIDS - 1);

   state_e           r_state;
   state_e           w_next;
   logic [PID_W-1:0] r_head;
   logic [PID_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             r_gnt;
   logic [PID_W-1:0] r_pid;
   logic             r_err_uf;
   logic             r_err_of;

   logic             w_init;
   logic             w_ready;
   logic             w_empty;
   logic             w_full;
   logic             w_do_alloc;
   logic             w_free_ok;
   logic             w_we;
   logic [PID_W-1:0] w_wdata;
   logic [PID_W-1:0] w_head_pid;
   logic             w_ready_o;
   logic             w_done_o;

   assign w_init  = (r_state == ST_INIT);
   assign w_ready = (r_state == ST_READY);
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_FULL);

   // No bypass: a PID freed this cycle is only grantable next cycle.
   assign w_do_alloc = w_ready & alloc_req & ~w_empty;

`ifdef PID_ALLOC_DFREE_CHECK_EN
   logic [NUM_PIDS-1:0] r_inuse;
   logic                r_err_df;
   logic                w_pid_used;

   // A grant of the same PID in this cycle makes the free legitimate.
   assign w_pid_used = r_inuse[free_pid]
                     | (w_do_alloc & (w_head_pid == free_pid));
   assign w_free_ok  = w_ready & free_valid & ~w_full & w_pid_used;

   always_ff @(posedge clk) begin
      if (reset || w_init) begin
         r_inuse  <= '0;
         r_err_df <= 1'b0;
      end else begin
         if (w_do_alloc) r_inuse[w_head_pid] <= 1'b1;
         // Clear after set: same-cycle grant+free leaves the bit at 0.
         if (w_free_ok) r_inuse[free_pid] <= 1'b0;
         if (w_ready & free_valid & ~w_full & ~w_pid_used)
            r_err_df <= 1'b1;
      end
   end

   assign err_double_free = r_err_df;
`else
   assign w_free_ok = w_ready & free_valid & ~w_full;
`endif

   // During INIT the tail pointer doubles as the fill counter.
   assign w_we    = w_init | w_free_ok;
   assign w_wdata = w_init ? r_tail : free_pid;

   pid_ram #(
      .AW (PID_W),
      .DW (PID_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_tail),
      .i_wdata (w_wdata),
      .i_raddr (r_head),
      .o_rdata (w_head_pid)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_INIT;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_INIT:  if (r_tail == C_LAST) w_next = ST_READY;
         ST_READY: w_next = ST_READY;
      endcase
   end

   always_comb begin
      w_ready_o = 1'b0;
      w_done_o  = 1'b0;
      unique case (r_state)
         ST_INIT: begin
            w_ready_o = 1'b0;
            w_done_o  = 1'b0;
         end
         ST_READY: begin
            w_ready_o = 1'b1;
            w_done_o  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_gnt    <= 1'b0;
         r_pid    <= '0;
         r_err_uf <= 1'b0;
         r_err_of <= 1'b0;
      end else begin
         r_gnt <= w_do_alloc;
         if (w_do_alloc) begin
            r_pid  <= w_head_pid;
            r_head <= r_head + 1'b1;
         end
         if (w_we) r_tail <= r_tail + 1'b1;
         unique case ({w_we, w_do_alloc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_ready & alloc_req & w_empty) r_err_uf <= 1'b1;
         if (free_valid & (w_init | w_full)) r_err_of <= 1'b1;
      end
   end

   assign alloc_gnt     = r_gnt;
   assign alloc_pid     = r_pid;
   assign free_ready    = w_ready_o;
   assign init_done     = w_done_o;
   assign free_count    = r_count;
   assign list_empty    = w_empty;
   assign err_underflow = r_err_uf;
   assign err_overflow  = r_err_of;

endmodule

// File: tb/tb_pid_alloc.sv
// Directed bench for pid_alloc with a queue scoreboard of expected PIDs.
// Ports of the DUT are all driven/observed; double-free cases need the macro.
module tb_pid_alloc;

   logic       clk;
   logic       reset;
   logic       alloc_req;
   logic       alloc_gnt;
   logic [8:0] alloc_pid;
   logic       free_valid;
   logic [8:0] free_pid;
   logic       free_ready;
   logic       init_done;
   logic [9:0] free_count;
   logic       list_empty;
   logic       err_underflow;
   logic       err_overflow;
`ifdef PID_ALLOC_DFREE_CHECK_EN
   logic       err_double_free;
`endif

   pid_alloc #(
      .PID_W (9),
      .CNT_W (10)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .alloc_req     (alloc_req),
      .alloc_gnt     (alloc_gnt),
      .alloc_pid     (alloc_pid),
      .free_valid    (free_valid),
      .free_pid      (free_pid),
      .free_ready    (free_ready),
      .init_done     (init_done),
      .free_count    (free_count),
      .list_empty    (list_empty),
`ifdef PID_ALLOC_DFREE_CHECK_EN
      .err_double_free (err_double_free),
`endif
      .err_underflow (err_underflow),
      .err_overflow  (err_overflow)
   );

   int   n_tests;
   int   n_fail;
   int   q[$];
   logic exp_gnt;
   int   n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      int e;
      @(posedge clk);
      #1;
      chk("gnt", 32'(alloc_gnt), 32'(exp_gnt));
      if (alloc_gnt === 1'b1) begin
         chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pid", 32'(alloc_pid), 32'(e));
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"}, 32'(alloc_gnt), 0);
      chk({tag, "_pid"}, 32'(alloc_pid), 0);
      chk({tag, "_fready"}, 32'(free_ready), 0);
      chk({tag, "_idone"}, 32'(init_done), 0);
      chk({tag, "_cnt"}, 32'(free_count), 0);
      chk({tag, "_empty"}, 32'(list_empty), 1);
      chk({tag, "_uf"}, 32'(err_underflow), 0);
      chk({tag, "_of"}, 32'(err_overflow), 0);
`ifdef PID_ALLOC_DFREE_CHECK_EN
      chk({tag, "_df"}, 32'(err_double_free), 0);
`endif
   endtask

   task automatic wait_init(output int cyc);
      cyc = 0;
      exp_gnt = 1'b0;
      for (int i = 0; i < 600; i++) begin
         tick();
         cyc++;
         if (init_done === 1'b1) begin
            alloc_req = 1'b0;
            break;
         end
      end
      chk("init_seen", 32'(init_done), 1);
   endtask

   task automatic alloc_one(input int exp_pid);
      alloc_req = 1'b1;
      exp_gnt = 1'b1;
      q.push_back(exp_pid);
      tick();
      alloc_req = 1'b0;
      exp_gnt = 1'b0;
   endtask

   task automatic free_one(input int pid);
      free_valid = 1'b1;
      free_pid = 9'(pid);
      exp_gnt = 1'b0;
      tick();
      free_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail = 0;
      exp_gnt = 1'b0;
      reset = 1'b1;
      alloc_req = 1'b0;
      free_valid = 1'b0;
      free_pid = '0;

      repeat (3) tick();
      chk_reset_vals("rst");

      // Requests during INIT must be ignored.
      reset = 1'b0;
      alloc_req = 1'b1;
      wait_init(n);
      chk("init_lat", 32'(n), 512);
      chk("init_cnt", 32'(free_count), 512);
      chk("init_empty", 32'(list_empty), 0);
      chk("init_fready", 32'(free_ready), 1);
      chk("init_uf", 32'(err_underflow), 0);
      chk("init_of", 32'(err_overflow), 0);

      for (int i = 0; i < 3; i++) alloc_one(i);
      tick();
      chk("cnt509", 32'(free_count), 509);

      for (int i = 3; i < 512; i++) alloc_one(i);
      chk("cnt0", 32'(free_count), 0);
      chk("empty0", 32'(list_empty), 1);
      chk("uf_pre", 32'(err_underflow), 0);

      alloc_req = 1'b1;
      exp_gnt = 1'b0;
      tick();
      alloc_req = 1'b0;
      chk("uf_set", 32'(err_underflow), 1);
      chk("empty_uf", 32'(list_empty), 1);

      free_one(7);
      chk("cnt_f7", 32'(free_count), 1);
      alloc_one(7);
      chk("cnt_a7", 32'(free_count), 0);

      // Alloc+free on an empty list: no bypass.
      alloc_req = 1'b1;
      free_valid = 1'b1;
      free_pid = 9'd5;
      exp_gnt = 1'b0;
      tick();
      free_valid = 1'b0;
      alloc_req = 1'b0;
      chk("sim_cnt", 32'(free_count), 1);
      chk("sim_uf", 32'(err_underflow), 1);
      alloc_one(5);
      chk("sim_cnt2", 32'(free_count), 0);

      for (int i = 0; i < 511; i++) free_one(i);
      chk("cnt511", 32'(free_count), 511);
`ifdef PID_ALLOC_DFREE_CHECK_EN
      chk("df_pre", 32'(err_double_free), 0);
      free_one(0);
      chk("df_set", 32'(err_double_free), 1);
      chk("df_cnt", 32'(free_count), 511);
`endif
      free_one(511);
      chk("cnt512", 32'(free_count), 512);
      chk("of_pre", 32'(err_overflow), 0);
      free_one(3);
      chk("of_set", 32'(err_overflow), 1);
      chk("of_cnt", 32'(free_count), 512);

      for (int i = 0; i < 100; i++) alloc_one(i);
      chk("cnt412", 32'(free_count), 412);

      alloc_req = 1'b1;
      reset = 1'b1;
      exp_gnt = 1'b0;
      tick();
      alloc_req = 1'b0;
      chk_reset_vals("mrst");
      tick();
      chk("sb_drained", 32'(q.size()), 0);

      // A free during INIT is dropped and flagged.
      reset = 1'b0;
      free_one(3);
      chk("of_init", 32'(err_overflow), 1);
      chk("init2_idone", 32'(init_done), 0);
      wait_init(n);
      chk("init2_lat", 32'(n), 511);
      chk("init2_cnt", 32'(free_count), 512);
      alloc_one(0);
      chk("post_cnt", 32'(free_count), 511);
      chk("sb_end", 32'(q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pid_alloc.md
Name: pid_alloc

Overview:
- Free-list manager for the packet-buffer slots (PIDs) of the packet store, which holds 512 slots of 32 x 520-bit beats each.
- The ingress store path requests a PID before writing a multi-beat packet. The egress pickup path returns the PID after the last beat is read out.
- Replaces the priority-encoder scan of the in-use bitmap with an O(1) FIFO of free PIDs, and adds occupancy reporting and error flags.

Parameters:
- PID_W, 9, PID width; NUM_PIDS = 2**PID_W (derived localparam, 512).
- CNT_W, 10, width of the free-count output; must equal PID_W+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_req  in  1  request one free PID this cycle
- alloc_gnt  out  1  one-cycle pulse; alloc_pid is valid
- alloc_pid  out  PID_W  granted PID
- free_valid  in  1  return free_pid to the list
- free_pid  in  PID_W  PID being released
- free_ready  out  1  high when frees are accepted (READY state)
- init_done  out  1  free list fully populated; allocation enabled
- free_count  out  CNT_W  number of PIDs currently free
- list_empty  out  1  free_count == 0
- err_underflow  out  1  sticky; alloc_req seen while list empty in READY
- err_overflow  out  1  sticky; free while free_count == NUM_PIDS, or free_valid while !free_ready

Behaviour:
- Storage: NUM_PIDS x PID_W RAM, head and tail pointers of PID_W bits. Pointers wrap naturally at NUM_PIDS. Count register is CNT_W bits.
- Reset values:
  - Outputs alloc_gnt=0, alloc_pid=0, free_ready=0, init_done=0, free_count=0, list_empty=1, err_underflow=0, err_overflow=0.
  - Internal: head=0, tail=0, init counter=0, state=INIT.
- States:
  - INIT: writes ram[i]=i for i=0..NUM_PIDS-1, one entry per cycle; tail and free_count increment each cycle.
  - INIT -> READY after the write of NUM_PIDS-1, i.e. after exactly NUM_PIDS cycles. At that point tail has wrapped to 0 and free_count=NUM_PIDS.
  - In READY, init_done=1 and free_ready=1, registered (rise in the first READY cycle).
  - INIT ignores alloc_req: no grant and no error. free_valid in INIT is dropped and sets err_overflow.
- Alloc (READY):
  - alloc_req sampled high with free_count>0 at edge t produces alloc_gnt=1 and alloc_pid=ram[head] in cycle t+1, then head++ and free_count--.
  - Held alloc_req means one grant per cycle.
  - With free_count==0 there is no grant and err_underflow is set.
- Free (READY):
  - free_valid with free_count<NUM_PIDS writes ram[tail]=free_pid, then tail++ and free_count++.
  - With free_count==NUM_PIDS the free is dropped and err_overflow is set.
- Simultaneous alloc and free in the same cycle:
  - Both are serviced and free_count is unchanged.
  - No bypass: if free_count==0 the alloc is not granted (err_underflow set), the free is stored, and the PID becomes grantable next cycle.
- Derived outputs: list_empty is combinational from free_count.
- Error flags: cleared only by reset.
- Reset mid-operation: all state is discarded, including PIDs outstanding in the store. The block re-enters INIT, and owners must treat every PID as reclaimed.
- Latency: alloc is 1 cycle request-to-grant; a freed PID is visible to free_count 1 cycle later.

Optional Feature:
- Macro PID_ALLOC_DFREE_CHECK_EN.
- Defined:
  - Adds a NUM_PIDS-bit in-use bitmap: cleared in INIT, bit set on grant, bit cleared on accepted free.
  - A free of a PID whose bit is already 0 is dropped and raises sticky output err_double_free (1 bit, reset 0). That port exists only when the macro is defined.
  - A same-cycle grant of PID p plus a free of p treats the free as valid: set-then-clear leaves the bit 0.
- Undefined: no bitmap and no port; every free under the count limit is accepted.

Decomposition:
- Package mmu_pkg:
  - PID_W=9, NUM_PIDS=512, BEATS_PER_PID=32.
  - Beat ctl codes CTL_INVALID=8'h00, CTL_START=8'h01, CTL_PAYLOAD=8'h02, CTL_END=8'h03, CTL_SINGLE=8'h04.
  - State encodings INIT/READY.
- One sub-module, pid_ram: simple dual-port RAM, one sync write port, one async read port at head.

Test Plan:
- Reset, then idle -> init_done rises 512 cycles after reset falls; free_count=512; list_empty=0; no grants during INIT even with alloc_req=1.
- After init, 3 consecutive alloc_req -> alloc_pid 0, 1, 2 on consecutive cycles, each 1 cycle after its request; free_count=509.
- Allocate all 512 then one more -> 513th gets no grant, err_underflow=1, list_empty=1; then free 7 -> next alloc returns 7.
- List empty, alloc_req and free_valid (pid 5) in the same cycle -> no grant that cycle and err_underflow=1; next-cycle request is granted pid 5.
- After init, free_valid pid 3 with free_count=512 -> dropped, err_overflow=1; with PID_ALLOC_DFREE_CHECK_EN, alloc 0, free 0, free 0 again -> second free raises err_double_free=1 and free_count unchanged.
- Assert reset mid-stream after 100 grants -> outputs return to reset values, INIT reruns, and first post-init grant is pid 0.
